// File: rtl/cmp_mem_pkg.sv
// Shared types and width helpers for the compaction memory server.
// Imported by the interface, the RAM and the server top.
package cmp_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    SERVE,
    DUMP
  } e_srv_state;

  localparam int DEF_DEPTH = 32;
  localparam int DEF_WIDTH = 8;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/cmp_mem_server_if.sv
// Host/controller bundle for cmp_mem_server.
// master drives requests, slave is the server.
interface cmp_mem_server_if
  import cmp_mem_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_WIDTH
);
  localparam int AW = addr_w(DEPTH);

  logic             i_go;
  logic             i_ld_valid;
  logic             o_ld_ready;
  logic [WIDTH-1:0] i_ld_data;
  logic             o_start;
  logic             i_rden;
  logic             i_wren;
  logic [AW-1:0]    i_addr;
  logic [WIDTH-1:0] i_wdata;
  logic [WIDTH-1:0] o_rdata;
  logic             i_done;
  logic             o_dp_valid;
  logic             i_dp_ready;
  logic [WIDTH-1:0] o_dp_data;
  logic             o_dp_last;
  logic             o_busy;
  logic             o_err;

  modport master (
    output i_go, i_ld_valid, i_ld_data,
    output i_rden, i_wren, i_addr, i_wdata,
    output i_done, i_dp_ready,
    input  o_ld_ready, o_start, o_rdata,
    input  o_dp_valid, o_dp_data, o_dp_last,
    input  o_busy, o_err
  );

  modport slave (
    input  i_go, i_ld_valid, i_ld_data,
    input  i_rden, i_wren, i_addr, i_wdata,
    input  i_done, i_dp_ready,
    output o_ld_ready, o_start, o_rdata,
    output o_dp_valid, o_dp_data, o_dp_last,
    output o_busy, o_err
  );
endinterface

// File: rtl/sp_ram_sync.sv
// Single-port RAM, synchronous write, registered read.
// Read register holds its value on cycles without a read.
module sp_ram_sync
  import cmp_mem_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_WIDTH,
  localparam int AW = addr_w(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_we,
  input  logic             i_re,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // array write; contents survive reset
  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_addr] <= i_wdata;
  end

  // registered read, cleared by reset so outputs start at 0
  always_ff @(posedge i_clk) begin
    if (i_rst)     o_rdata <= '0;
    else if (i_re) o_rdata <= mem[i_addr];
  end

endmodule

// File: rtl/cmp_mem_server.sv
// Memory server: load stream -> serve controller -> dump stream.
// Single RAM port muxed by FSM state.
module cmp_mem_server
  import cmp_mem_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_WIDTH
) (
  input logic i_clk,
  input logic i_rst,
  cmp_mem_server_if.slave bus
);
  localparam int AW = addr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  e_srv_state       state;
  logic [CW-1:0]    ld_ptr;
  logic [CW-1:0]    wr_cnt;
  logic [CW-1:0]    wr_cnt_nxt;
  logic [CW-1:0]    dp_ptr;
  logic             dp_valid;
  logic             dp_last;
  logic             err;
  logic             ram_we;
  logic             ram_re;
  logic [AW-1:0]    ram_addr;
  logic [WIDTH-1:0] ram_wdata;
  logic [WIDTH-1:0] ram_rdata;
  logic             ld_acc;
  logic             dp_issue;
  logic             dp_xfer;
  logic             strobe;
  logic             wr_full;

  assign ld_acc   = (state == LOAD) && bus.i_ld_valid;
  assign dp_issue = (state == DUMP)
                 && (!dp_valid || bus.i_dp_ready)
                 && (dp_ptr < wr_cnt);
  assign dp_xfer  = dp_valid && bus.i_dp_ready;
  assign strobe   = bus.i_rden || bus.i_wren;
  assign wr_full  = (wr_cnt == FULL);

  // write count including this cycle's write, saturating
  always_comb begin
    wr_cnt_nxt = wr_cnt;
    if (bus.i_wren && !wr_full)
      wr_cnt_nxt = wr_cnt + 1'b1;
  end

  // one requester per state drives the RAM port
  always_comb begin
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    unique case (1'b1)
      ld_acc: begin
        ram_we    = 1'b1;
        ram_addr  = ld_ptr[AW-1:0];
        ram_wdata = bus.i_ld_data;
      end
      (state == SERVE): begin
        ram_we    = bus.i_wren;
        ram_re    = bus.i_rden && !bus.i_wren;
        ram_addr  = bus.i_addr;
        ram_wdata = bus.i_wdata;
      end
      dp_issue: begin
        ram_re    = 1'b1;
        ram_addr  = dp_ptr[AW-1:0];
      end
      default: ;
    endcase
  end

  sp_ram_sync #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_ram (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (ram_we),
    .i_re    (ram_re),
    .i_addr  (ram_addr),
    .i_wdata (ram_wdata),
    .o_rdata (ram_rdata)
  );

  // job sequencing, pointers, dump handshake and sticky error
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      ld_ptr   <= '0;
      wr_cnt   <= '0;
      dp_ptr   <= '0;
      dp_valid <= 1'b0;
      dp_last  <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (strobe && state != SERVE) err <= 1'b1;
      case (state)
        IDLE: begin
          if (bus.i_go) begin
            ld_ptr <= '0;
            state  <= LOAD;
          end
        end
        LOAD: begin
          if (ld_acc) begin
            ld_ptr <= ld_ptr + 1'b1;
            if (ld_ptr == FULL - 1'b1) state <= START;
          end
        end
        START: begin
          wr_cnt <= '0;
          state  <= SERVE;
        end
        SERVE: begin
          wr_cnt <= wr_cnt_nxt;
          if (bus.i_rden && bus.i_wren) err <= 1'b1;
          if (bus.i_wren && wr_full)    err <= 1'b1;
          if (bus.i_done) begin
            dp_ptr <= '0;
            state  <= (wr_cnt_nxt == '0) ? IDLE : DUMP;
          end
        end
        DUMP: begin
          if (dp_issue) begin
            dp_ptr   <= dp_ptr + 1'b1;
            dp_valid <= 1'b1;
            dp_last  <= (dp_ptr == wr_cnt - 1'b1);
          end else if (dp_xfer) begin
            dp_valid <= 1'b0;
            dp_last  <= 1'b0;
            if (dp_last) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_ld_ready = (state == LOAD);
  assign bus.o_start    = (state == START);
  assign bus.o_rdata    = ram_rdata;
  assign bus.o_dp_data  = ram_rdata;
  assign bus.o_dp_valid = dp_valid;
  assign bus.o_dp_last  = dp_last;
  assign bus.o_busy     = (state != IDLE);
  assign bus.o_err      = err;

endmodule
